// File: rtl/irq_controller.sv
// Platform interrupt controller: synchronizes, latches, masks and
// prioritizes external sources, with a claim/complete service handshake.
module irq_controller #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               rvalid,
    output logic               interrupt,
    output logic               busy
);

    logic [NUM_SRC-1:0] s0, s1, s2;
    logic [NUM_SRC-1:0] pending, enable, mode;
    logic [4:0]         claim_id;

    logic [NUM_SRC-1:0] cand, edge_ev, claim_clr, w1c, pend_nxt;
    logic [4:0]         winner;
    logic               sel_pend, sel_en, sel_mode, sel_claim;
    logic               claim_ok, complete_ok;
    logic [31:0]        rd_val;

    assign sel_pend  = (addr == 2'd0);
    assign sel_en    = (addr == 2'd1);
    assign sel_mode  = (addr == 2'd2);
    assign sel_claim = (addr == 2'd3);

    assign cand    = pending & enable;
    assign edge_ev = s1 & ~s2;

    // Downward scan so the lowest set index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) winner = 5'(i);
        end
    end

    assign claim_ok    = rd_en && sel_claim && (|cand) && !busy;
    assign complete_ok = wr_en && sel_claim && busy
                         && (wdata == {27'b0, claim_id});

    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr[i] = claim_ok && (winner == 5'(i));
        end
    end

    assign w1c = (wr_en && sel_pend) ? wdata[NUM_SRC-1:0] : '0;

    // Edge bits: a new edge outranks any clear; level bits track s1.
    assign pend_nxt = (mode & ((pending & ~(claim_clr | w1c)) | edge_ev))
                    | (~mode & s1);

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_pend:  rd_val[NUM_SRC-1:0] = pending;
            sel_en:    rd_val[NUM_SRC-1:0] = enable;
            sel_mode:  rd_val[NUM_SRC-1:0] = mode;
            sel_claim: rd_val = claim_ok ? (32'(winner) + 32'd1) : '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0        <= '0;
            s1        <= '0;
            s2        <= '0;
            pending   <= '0;
            enable    <= '0;
            mode      <= '0;
            busy      <= 1'b0;
            claim_id  <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            s0        <= irq_src;
            s1        <= s0;
            s2        <= s1;
            pending   <= pend_nxt;
            interrupt <= (|cand) & ~busy;
            rvalid    <= rd_en;
            if (rd_en) rdata <= rd_val;
            if (complete_ok) begin
                busy     <= 1'b0;
                claim_id <= '0;
            end else if (claim_ok) begin
                busy     <= 1'b1;
                claim_id <= winner + 5'd1;
            end
            if (wr_en && sel_en)   enable <= wdata[NUM_SRC-1:0];
            if (wr_en && sel_mode) mode   <= wdata[NUM_SRC-1:0];
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; register reads are checked by a
// scoreboard monitor, port-level status by direct compares.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_src;
    logic        wr_en, rd_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid, interrupt, busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] m_exp;
    string       m_name;

    irq_controller #(.NUM_SRC(8)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .interrupt(interrupt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid got=%h want=none", rdata);
            end else begin
                m_exp  = exp_q.pop_front();
                m_name = name_q.pop_front();
                if (rdata !== m_exp) begin
                    errors++;
                    $display("FAIL %s got=%h want=%h", m_name, rdata, m_exp);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e,
                      input string n);
        rd_en = 1'b1;
        addr  = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
        wdata = '0;
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_src = v;
        @(negedge clk);
        irq_src = '0;
    endtask

    initial begin
        reset   = 1'b0;
        irq_src = 8'hFF;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = '0;
        wdata   = '0;

        // Reset with all sources high
        @(negedge clk);
        tick(2);
        chk("rst_interrupt", {31'b0, interrupt}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rdata", rdata, 0);
        reset   = 1'b1;
        irq_src = '0;
        tick(3);
        rd(2'd0, 0, "rst_pending");
        rd(2'd1, 0, "rst_enable");
        rd(2'd2, 0, "rst_mode");
        rd(2'd3, 0, "rst_claim");

        // Single edge source, latency and claim/complete
        wr(2'd1, 32'h04);
        wr(2'd2, 32'h04);
        pulse(8'h04);
        tick(1);
        chk("int_before_pend", {31'b0, interrupt}, 0);
        tick(1);
        rd(2'd0, 32'h04, "pend_src2");
        chk("int_src2", {31'b0, interrupt}, 1);
        rd(2'd3, 32'd3, "claim_src2");
        chk("busy_claim", {31'b0, busy}, 1);
        rd(2'd0, 0, "pend_after_claim");
        chk("int_drop_busy", {31'b0, interrupt}, 0);
        rd(2'd3, 0, "claim_while_busy");
        wr(2'd3, 32'd5);
        chk("busy_bad_complete", {31'b0, busy}, 1);
        wr(2'd3, 32'd3);
        chk("busy_complete", {31'b0, busy}, 0);
        chk("int_after_complete", {31'b0, interrupt}, 0);

        // Priority across three edges; masking keeps pending
        wr(2'd1, 32'hFF);
        wr(2'd2, 32'hFF);
        pulse(8'h52);
        tick(2);
        wr(2'd1, 32'h00);
        rd(2'd0, 32'h52, "pend_masked");
        chk("int_masked", {31'b0, interrupt}, 0);
        wr(2'd1, 32'hFF);
        rd(2'd3, 32'd2, "claim_first");
        wr(2'd3, 32'd2);
        rd(2'd3, 32'd5, "claim_second");
        wr(2'd3, 32'd5);
        rd(2'd3, 32'd7, "claim_third");
        wr(2'd3, 32'd7);
        rd(2'd3, 0, "claim_empty");
        chk("busy_empty", {31'b0, busy}, 0);

        // Level source
        wr(2'd2, 32'h00);
        wr(2'd1, 32'h01);
        irq_src = 8'h01;
        tick(4);
        rd(2'd3, 32'd1, "claim_lvl");
        tick(1);
        chk("int_lvl_busy", {31'b0, interrupt}, 0);
        wr(2'd3, 32'd1);
        chk("busy_lvl_done", {31'b0, busy}, 0);
        chk("int_at_complete", {31'b0, interrupt}, 0);
        tick(1);
        chk("int_lvl_reraise", {31'b0, interrupt}, 1);
        wr(2'd0, 32'h01);
        rd(2'd0, 32'h01, "pend_lvl_w1c");
        irq_src = '0;
        tick(4);
        rd(2'd0, 0, "pend_lvl_drop");
        chk("int_lvl_drop", {31'b0, interrupt}, 0);

        // Edge event coincident with W1C: set wins
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'h00);
        pulse(8'h08);
        tick(1);
        wr(2'd0, 32'h08);
        rd(2'd0, 32'h08, "pend_set_wins");
        wr(2'd0, 32'h08);
        rd(2'd0, 0, "pend_w1c");

        // Reset during service
        wr(2'd1, 32'hFF);
        pulse(8'h08);
        tick(2);
        rd(2'd3, 32'd4, "claim_src3");
        chk("busy_src3", {31'b0, busy}, 1);
        reset = 1'b0;
        #1;
        chk("busy_async_rst", {31'b0, busy}, 0);
        chk("int_async_rst", {31'b0, interrupt}, 0);
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        rd(2'd3, 0, "claim_post_rst");
        rd(2'd1, 0, "en_post_rst");

        tick(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL read_drain got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
